// File: rtl/score_display_pkg.sv
// Shared constants, state encoding and helpers for the score/lives seven-segment display.
package score_display_pkg;

    localparam int unsigned SCORE_W     = 7;
    localparam int unsigned BCD_W       = 8;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned SEG_W       = 7;
    localparam int unsigned AN_W        = 4;
    localparam int unsigned LIVES_W     = 2;
    localparam int unsigned SHIFT_STEPS = 7;
    localparam int unsigned CNT_W       = 3;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] SEG_BLANK   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 7'b0010000;

    localparam logic [AN_W-1:0] AN_OFF   = 4'hF;
    localparam logic [AN_W-1:0] AN_ONES  = 4'b1110;
    localparam logic [AN_W-1:0] AN_TENS  = 4'b1101;
    localparam logic [AN_W-1:0] AN_LIVES = 4'b0111;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'd0,
        CONV_SHIFT  = 2'd1,
        CONV_COMMIT = 2'd2
    } conv_state_e;

    function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = SEG_DIGIT_0;
            4'd1:    s = SEG_DIGIT_1;
            4'd2:    s = SEG_DIGIT_2;
            4'd3:    s = SEG_DIGIT_3;
            4'd4:    s = SEG_DIGIT_4;
            4'd5:    s = SEG_DIGIT_5;
            4'd6:    s = SEG_DIGIT_6;
            4'd7:    s = SEG_DIGIT_7;
            4'd8:    s = SEG_DIGIT_8;
            4'd9:    s = SEG_DIGIT_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift
    function automatic logic [DIGIT_W-1:0] dabble_adj(input logic [DIGIT_W-1:0] n);
        return (n >= 4'd5) ? DIGIT_W'(n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble: converts a clamped 7-bit score to two BCD digits over 7 shift clocks.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [SCORE_W-1:0] bin_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [BCD_W-1:0]   bcd_o,
    output logic [SCORE_W-1:0] bin_o
);

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] snap_q, snap_d;
    logic [BCD_W-1:0]   adj_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            sr_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    assign adj_c = {dabble_adj(work_q[7:4]), dabble_adj(work_q[3:0])};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        case (state_q)
            CONV_IDLE: begin
                if (start_i) begin
                    sr_d    = (bin_i > SCORE_MAX) ? SCORE_MAX : bin_i;
                    work_d  = '0;
                    cnt_d   = '0;
                    snap_d  = bin_i;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                {work_d, sr_d} = {adj_c, sr_q} << 1;
                cnt_d = CNT_W'(cnt_q + 3'd1);
                if (cnt_q == CNT_W'(SHIFT_STEPS - 1)) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                state_d = CONV_IDLE;
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase
    end

    // Result and snapshot are presented during COMMIT; the consumer latches them on valid_o
    assign busy_o  = (state_q != CONV_IDLE);
    assign valid_o = (state_q == CONV_COMMIT);
    assign bcd_o   = work_q;
    assign bin_o   = snap_q;

endmodule

// File: rtl/score_display.sv
// Score/lives seven-segment driver: BCD conversion, 4-digit scan, game-over blink.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 17,
    parameter int unsigned BLINK_BITS   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic [LIVES_W-1:0] lives,
    input  logic               done,
    output logic [SEG_W-1:0]   seg,
    output logic [AN_W-1:0]    an,
    output logic               dp
);

    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [BLINK_BITS-1:0]   blink_q, blink_d;
    logic [DIGIT_W-1:0]      tens_q, tens_d, ones_q, ones_d;
    logic [SCORE_W-1:0]      last_q, last_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [AN_W-1:0]         an_q, an_d;

    logic                    conv_busy, conv_valid, start_c, blank_c;
    logic [BCD_W-1:0]        conv_bcd;
    logic [SCORE_W-1:0]      conv_bin;
    logic [1:0]              sel_c;

    assign start_c = !conv_busy && (score != last_q);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_c),
        .bin_i   (score),
        .busy_o  (conv_busy),
        .valid_o (conv_valid),
        .bcd_o   (conv_bcd),
        .bin_o   (conv_bin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q  <= '0;
            blink_q <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            last_q  <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
        end else begin
            scan_q  <= scan_d;
            blink_q <= blink_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            last_q  <= last_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign sel_c   = scan_q[REFRESH_BITS-1 -: 2];
    assign blank_c = done && blink_q[BLINK_BITS-1];

    always_comb begin
        scan_d  = REFRESH_BITS'(scan_q + REFRESH_BITS'(1));
        blink_d = done ? BLINK_BITS'(blink_q + BLINK_BITS'(1)) : '0;
        tens_d  = tens_q;
        ones_d  = ones_q;
        last_d  = last_q;
        if (conv_valid) begin
            tens_d = conv_bcd[7:4];
            ones_d = conv_bcd[3:0];
            last_d = conv_bin;
        end
    end

    // Digit decode for the currently selected position; tens has leading-zero suppression
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (!blank_c) begin
            case (sel_c)
                2'd0: begin
                    an_d  = AN_ONES;
                    seg_d = seg_encode(ones_q);
                end
                2'd1: begin
                    if (tens_q != '0) begin
                        an_d  = AN_TENS;
                        seg_d = seg_encode(tens_q);
                    end
                end
                2'd3: begin
                    an_d  = AN_LIVES;
                    seg_d = seg_encode({2'b00, lives});
                end
                default: begin
                    an_d  = AN_OFF;
                    seg_d = SEG_BLANK;
                end
            endcase
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: arithmetic reference model feeds a queue, a monitor compares.
module tb_score_display;

    localparam int unsigned RB = 4;
    localparam int unsigned BB = 6;

    logic       clk;
    logic       rst_n;
    logic [6:0] score;
    logic [1:0] lives;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int tests_run = 0;
    int tests_failed = 0;

    logic [10:0] exp_q[$];
    logic [6:0]  pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference state: displayed digits, last converted score, in-flight conversion
    int m_tens, m_ones, m_last, m_snap, m_busy, m_scan, m_blink;

    score_display #(.REFRESH_BITS(RB), .BLINK_BITS(BB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .score (score),
        .lives (lives),
        .done  (done),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        int sel, v;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        if (!rst_n) begin
            m_tens = 0; m_ones = 0; m_last = 0; m_snap = 0;
            m_busy = 0; m_scan = 0; m_blink = 0;
            exp_q.delete();
        end else begin
            sel   = (m_scan / (1 << (RB - 2))) % 4;
            e_an  = 4'hF;
            e_seg = 7'h7F;
            if (!(done && m_blink >= (1 << (BB - 1)))) begin
                if (sel == 0) begin
                    e_an = 4'b1110; e_seg = pat[m_ones];
                end else if (sel == 1 && m_tens != 0) begin
                    e_an = 4'b1101; e_seg = pat[m_tens];
                end else if (sel == 3) begin
                    e_an = 4'b0111; e_seg = pat[int'(lives)];
                end
            end
            exp_q.push_back({e_an, e_seg});
            if (m_busy == 0) begin
                if (int'(score) != m_last) begin
                    m_snap = int'(score);
                    m_busy = 8;
                end
            end else begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    v = (m_snap > 99) ? 99 : m_snap;
                    m_tens = v / 10;
                    m_ones = v % 10;
                    m_last = m_snap;
                end
            end
            m_scan  = (m_scan + 1) % (1 << RB);
            m_blink = done ? (m_blink + 1) % (1 << BB) : 0;
        end
    end

    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst_n) begin
            tests_run++;
            if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_state t=%0t: seg=%b an=%b dp=%b expected seg=1111111 an=1111 dp=1",
                         $time, seg, an, dp);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (seg !== e[6:0] || an !== e[10:7] || dp !== 1'b1) begin
                tests_failed++;
                $display("FAIL display t=%0t score=%0d: seg=%b an=%b dp=%b expected seg=%b an=%b dp=1",
                         $time, score, seg, an, dp, e[6:0], e[10:7]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        score = 7'($urandom_range(0, 127));
        lives = 2'($urandom_range(0, 3));
        done  = 1'b1;
        step(3);
        score = 7'd0; lives = 2'd3; done = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(32);
        score = 7'd47;
        step(40);
        score = 7'd120;
        step(40);
        score = 7'd12;
        step(3);
        score = 7'd13;
        step(40);
        done = 1'b1;
        step(140);
        done = 1'b0;
        step(20);
        score = 7'd55;
        step(3);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(40);
        for (int i = 0; i < 40; i++) begin
            score = 7'($urandom_range(0, 127));
            lives = 2'($urandom_range(0, 3));
            done  = ($urandom_range(0, 5) == 0);
            step($urandom_range(1, 25));
        end
        done = 1'b0;
        step(40);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
